// File: rtl/sd_block_bridge.sv
// sd_block_bridge: arbitrates three SD block requesters onto one host data-slot engine, 512 bytes per block.
// Define SD_BRIDGE_WRITE_EN to build the write-back path; the default build is read-only.
module sd_block_bridge #(
   parameter logic [23:0] TIMEOUT = 24'd1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  sd_rd,
   input  logic [2:0]  sd_wr,
   input  logic [31:0] sd_lba0,
   input  logic [31:0] sd_lba1,
   input  logic [31:0] sd_lba2,
   output logic [2:0]  sd_ack,
   output logic [8:0]  sd_buff_addr,
   output logic [7:0]  sd_buff_dout,
   output logic        sd_buff_wr,
   input  logic [7:0]  sd_buff_din0,
   input  logic [7:0]  sd_buff_din1,
   input  logic [7:0]  sd_buff_din2,
   output logic        host_req,
   output logic        host_write,
   output logic [1:0]  host_slot,
   output logic [31:0] host_lba,
   input  logic        host_gnt,
   input  logic        host_rd_valid,
   input  logic [7:0]  host_rd_data,
   output logic        host_wr_valid,
   output logic [7:0]  host_wr_data,
   input  logic        host_wr_ready,
   output logic        busy,
   output logic        err,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_REQ      = 3'd1;
   localparam logic [2:0] S_RD_XFER  = 3'd2;
`ifdef SD_BRIDGE_WRITE_EN
   localparam logic [2:0] S_WR_FETCH = 3'd3;
   localparam logic [2:0] S_WR_XFER  = 3'd4;
`endif
   localparam logic [2:0] S_DONE     = 3'd5;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [1:0]  slot;
   logic [31:0] lba;
   logic [8:0]  count;
   logic [23:0] idle_cnt;
   logic [2:0]  req_vec;
   logic [1:0]  pick_slot;
   logic [31:0] pick_lba;
   logic        xfer;
   logic        active;
   logic        rd_hs;
   logic        wr_hs;
   logic        event_hit;
   logic        timed_out;

`ifdef SD_BRIDGE_WRITE_EN
   logic        dir_wr;
   logic        pick_wr;
   logic [7:0]  din_sel;
   logic [7:0]  wr_data_q;
   logic        wr_hold;

   assign req_vec = sd_rd | sd_wr;
   assign xfer    = (state == S_RD_XFER) || (state == S_WR_FETCH) || (state == S_WR_XFER);
`else
   logic unused_write_inputs;

   assign unused_write_inputs = ^{sd_wr, sd_buff_din0, sd_buff_din1, sd_buff_din2};
   assign req_vec = sd_rd;
   assign xfer    = (state == S_RD_XFER);
`endif

   // Fixed priority: the lowest-numbered requesting slot wins.
   always_comb begin
      pick_slot = 2'd0;
      if (req_vec[0])      pick_slot = 2'd0;
      else if (req_vec[1]) pick_slot = 2'd1;
      else if (req_vec[2]) pick_slot = 2'd2;
   end

   always_comb begin
      case (pick_slot)
         2'd0:    pick_lba = sd_lba0;
         2'd1:    pick_lba = sd_lba1;
         default: pick_lba = sd_lba2;
      endcase
   end

`ifdef SD_BRIDGE_WRITE_EN
   // A slot asking for both directions is served as a read.
   always_comb begin
      case (pick_slot)
         2'd0:    pick_wr = !sd_rd[0];
         2'd1:    pick_wr = !sd_rd[1];
         default: pick_wr = !sd_rd[2];
      endcase
   end

   always_comb begin
      case (slot)
         2'd0:    din_sel = sd_buff_din0;
         2'd1:    din_sel = sd_buff_din1;
         default: din_sel = sd_buff_din2;
      endcase
   end

   // host_wr_valid/host_wr_data are held for as long as host_wr_ready stays low; a byte moves only on valid && ready.
   assign wr_hs = (state == S_WR_XFER) && host_wr_ready;
`else
   assign wr_hs = 1'b0;
`endif

   assign active    = (state == S_REQ) || xfer;
   assign rd_hs     = (state == S_RD_XFER) && host_rd_valid;
   assign event_hit = host_gnt || host_rd_valid || wr_hs;
   assign timed_out = active && !event_hit && (idle_cnt == TIMEOUT - 24'd1);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (|req_vec) state_nxt = S_REQ;
`ifdef SD_BRIDGE_WRITE_EN
         S_REQ:     if (host_gnt) state_nxt = dir_wr ? S_WR_FETCH : S_RD_XFER;
         S_WR_FETCH: state_nxt = S_WR_XFER;
         S_WR_XFER: if (wr_hs) state_nxt = (count == 9'd511) ? S_DONE : S_WR_FETCH;
`else
         S_REQ:     if (host_gnt) state_nxt = S_RD_XFER;
`endif
         S_RD_XFER: if (rd_hs && count == 9'd511) state_nxt = S_DONE;
         S_DONE:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (timed_out) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         slot     <= 2'd0;
         lba      <= 32'd0;
         count    <= 9'd0;
         idle_cnt <= 24'd0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && |req_vec) begin
            slot <= pick_slot;
            lba  <= pick_lba;
         end
         if (timed_out)                     count <= 9'd0;
         else if (state == S_REQ && host_gnt) count <= 9'd0;
         else if (rd_hs || wr_hs)           count <= count + 9'd1;
         if (!active || event_hit || timed_out) idle_cnt <= 24'd0;
         else                                   idle_cnt <= idle_cnt + 24'd1;
      end
   end

`ifdef SD_BRIDGE_WRITE_EN
   // Buffer RAM data lags the address by one cycle, so the first WR_XFER cycle forwards din live and then holds it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_wr    <= 1'b0;
         wr_hold   <= 1'b0;
         wr_data_q <= 8'd0;
      end else begin
         if (state == S_IDLE && |req_vec) dir_wr <= pick_wr;
         if (state == S_WR_XFER && !wr_hold) begin
            wr_hold   <= 1'b1;
            wr_data_q <= din_sel;
         end
         if (state_nxt != S_WR_XFER) wr_hold <= 1'b0;
      end
   end

   assign host_write    = dir_wr;
   assign host_wr_valid = (state == S_WR_XFER);
   assign host_wr_data  = !host_wr_valid ? 8'd0 : (wr_hold ? wr_data_q : din_sel);
`else
   assign host_write    = 1'b0;
   assign host_wr_valid = 1'b0;
   assign host_wr_data  = 8'd0;
`endif

   assign busy         = (state != S_IDLE);
   assign host_req     = (state == S_REQ);
   assign host_slot    = slot;
   assign host_lba     = lba;
   assign sd_ack       = xfer ? (3'b001 << slot) : 3'b000;
   assign sd_buff_addr = count;
   assign sd_buff_wr   = rd_hs;
   assign sd_buff_dout = rd_hs ? host_rd_data : 8'd0;
   assign err          = timed_out;
   assign state_dbg    = state;

endmodule

// File: tb/tb_sd_block_bridge.sv
// Bench for sd_block_bridge: transaction-level model (expected request/byte queues) checked every cycle.
// Write scenario is built only with SD_BRIDGE_WRITE_EN; otherwise sd_wr must be ignored.
module tb_sd_block_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  sd_rd, sd_wr;
   logic [31:0] sd_lba0, sd_lba1, sd_lba2;
   logic [2:0]  sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din0, sd_buff_din1, sd_buff_din2;
   logic        host_req, host_write;
   logic [1:0]  host_slot;
   logic [31:0] host_lba;
   logic        host_gnt, host_rd_valid;
   logic [7:0]  host_rd_data;
   logic        host_wr_valid;
   logic [7:0]  host_wr_data;
   logic        host_wr_ready;
   logic        busy, err;
   logic [2:0]  state_dbg;

   sd_block_bridge #(.TIMEOUT(24'd16)) dut (
      .clk(clk), .reset(reset),
      .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_lba0(sd_lba0), .sd_lba1(sd_lba1), .sd_lba2(sd_lba2),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr),
      .sd_buff_din0(sd_buff_din0), .sd_buff_din1(sd_buff_din1), .sd_buff_din2(sd_buff_din2),
      .host_req(host_req), .host_write(host_write), .host_slot(host_slot), .host_lba(host_lba),
      .host_gnt(host_gnt), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
      .host_wr_valid(host_wr_valid), .host_wr_data(host_wr_data), .host_wr_ready(host_wr_ready),
      .busy(busy), .err(err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   logic [34:0] exp_req_q[$];   // {write, slot, lba}
   logic [16:0] exp_q[$];       // {addr, data} of each requester-buffer write
   logic [7:0]  exp_host_q[$];  // bytes the host must receive on writes
   int          cur_slot = 0;
   int          strobe_cnt = 0;
   int          wr_acc = 0;
   int          err_seen = 0;
   logic [8:0]  last_addr = 9'd0;
   logic [7:0]  last_data = 8'd0;
   logic [2:0]  ack_prev = 3'b000;
   logic [8:0]  ram_addr = 9'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat(input int sel, input int i);
      case (sel)
         0:       pat = i[7:0];
         1:       pat = 8'(i * 3 + 7);
         default: pat = ~i[7:0];
      endcase
   endfunction

   task automatic monitor();
      logic [34:0] r;
      logic [16:0] e;
      logic [2:0]  exp_ack;
      exp_ack = 3'b001 << cur_slot[1:0];
      check("ack_onehot0", 32'($onehot0(sd_ack)), 32'd1);
      if (host_req) begin
         check("req_pending", 32'(exp_req_q.size() != 0), 32'd1);
         if (exp_req_q.size() != 0) begin
            r = exp_req_q[0];
            check("req_write", 32'(host_write), 32'(r[34]));
            check("req_slot", 32'(host_slot), 32'(r[33:32]));
            check("req_lba", host_lba, r[31:0]);
         end
      end
      if (sd_buff_wr) begin
         strobe_cnt++;
         last_addr = sd_buff_addr;
         last_data = sd_buff_dout;
         check("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("buff_addr", 32'(sd_buff_addr), 32'(e[16:8]));
            check("buff_dout", 32'(sd_buff_dout), 32'(e[7:0]));
            check("strobe_ack", 32'(sd_ack), 32'(exp_ack));
         end
      end
      if (host_wr_valid && host_wr_ready) begin
         wr_acc++;
         check("wr_pending", 32'(exp_host_q.size() != 0), 32'd1);
         if (exp_host_q.size() != 0) begin
            check("host_wr_data", 32'(host_wr_data), 32'(exp_host_q.pop_front()));
            check("wr_ack", 32'(sd_ack), 32'(exp_ack));
         end
      end
      if (err) err_seen++;
   endtask

   // One cycle: compare at the falling edge, then apply requester/RAM reactions just after the rising edge.
   task automatic tick();
      @(negedge clk);
      monitor();
      ram_addr = sd_buff_addr;
      @(posedge clk);
      #1;
      sd_buff_din2 = ram_addr[7:0] ^ 8'h5A;
      for (int i = 0; i < 3; i++) begin
         if (sd_ack[i] && !ack_prev[i]) begin
            sd_rd[i] = 1'b0;
            sd_wr[i] = 1'b0;
         end
      end
      ack_prev = sd_ack;
   endtask

   task automatic expect_req(input logic w, input logic [1:0] s, input logic [31:0] l);
      exp_req_q.push_back({w, s, l});
   endtask

   task automatic wait_req(output bit ok);
      int n = 0;
      while (!host_req && n < 30) begin
         tick();
         n++;
      end
      ok = host_req;
      check("host_req_seen", 32'(host_req), 32'd1);
   endtask

   task automatic grant(input int gnt_delay);
      logic [34:0] r;
      repeat (gnt_delay) tick();
      host_gnt = 1'b1;
      tick();
      host_gnt = 1'b0;
      r = exp_req_q.pop_front();
      cur_slot = int'(r[33:32]);
   endtask

   task automatic serve_read(input int gnt_delay, input int sel, input int gap_every, input int n_bytes);
      bit ok;
      logic [8:0] a;
      wait_req(ok);
      if (!ok) return;
      grant(gnt_delay);
      for (int i = 0; i < n_bytes; i++) begin
         a = i[8:0];
         exp_q.push_back({a, pat(sel, i)});
         if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
            host_rd_data = 8'hEE;
            tick();
         end
         host_rd_valid = 1'b1;
         host_rd_data  = pat(sel, i);
         tick();
         host_rd_valid = 1'b0;
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ack"}, 32'(sd_ack), 32'd0);
      check({tag, "_buff_wr"}, 32'(sd_buff_wr), 32'd0);
      check({tag, "_buff_addr"}, 32'(sd_buff_addr), 32'd0);
      check({tag, "_buff_dout"}, 32'(sd_buff_dout), 32'd0);
      check({tag, "_host_req"}, 32'(host_req), 32'd0);
      check({tag, "_host_write"}, 32'(host_write), 32'd0);
      check({tag, "_host_slot"}, 32'(host_slot), 32'd0);
      check({tag, "_host_lba"}, host_lba, 32'd0);
      check({tag, "_wr_valid"}, 32'(host_wr_valid), 32'd0);
      check({tag, "_wr_data"}, 32'(host_wr_data), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
      check({tag, "_state"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      int s0, e0;
      reset = 1'b1;
      sd_rd = 3'b000; sd_wr = 3'b000;
      sd_lba0 = 32'd0; sd_lba1 = 32'd0; sd_lba2 = 32'd0;
      sd_buff_din0 = 8'd0; sd_buff_din1 = 8'd0; sd_buff_din2 = 8'd0;
      host_gnt = 1'b0; host_rd_valid = 1'b0; host_rd_data = 8'd0; host_wr_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      tick();
      check_idle_outputs("post_reset");

      // Single read, slot 1, grant after 3 cycles, back-to-back bytes i&0xFF.
      sd_lba1 = 32'h1234;
      sd_rd   = 3'b010;
      expect_req(1'b0, 2'd1, 32'h1234);
      tick();
      check("s1_host_req", 32'(host_req), 32'd1);
      check("s1_host_lba", host_lba, 32'h0000_1234);
      check("s1_host_slot", 32'(host_slot), 32'd1);
      check("s1_busy", 32'(busy), 32'd1);
      s0 = strobe_cnt;
      serve_read(2, 0, 0, 512);
      check("s1_strobes", 32'(strobe_cnt - s0), 32'd512);
      check("s1_last_addr", 32'(last_addr), 32'd511);
      check("s1_last_data", 32'(last_data), 32'hFF);
      check("s1_done_busy", 32'(busy), 32'd1);
      check("s1_done_ack", 32'(sd_ack), 32'd0);
      tick();
      check("s1_busy_clear", 32'(busy), 32'd0);
      check("s1_queue_empty", 32'(exp_q.size()), 32'd0);

      // Slots 0 and 2 together: 0 first, then 2, acks never overlapping.
      sd_lba0 = 32'hA0;
      sd_lba2 = 32'hA2;
      sd_rd   = 3'b101;
      expect_req(1'b0, 2'd0, 32'hA0);
      expect_req(1'b0, 2'd2, 32'hA2);
      serve_read(0, 1, 7, 512);
      check("s2_first_slot", 32'(cur_slot), 32'd0);
      serve_read(1, 2, 0, 512);
      check("s2_second_slot", 32'(cur_slot), 32'd2);
      tick();
      check("s2_idle", 32'(busy), 32'd0);
      check("s2_req_queue", 32'(exp_req_q.size()), 32'd0);

      // Host stalls after byte 100: err 16 cycles later, then the next request is served.
      sd_lba1 = 32'h77;
      sd_rd   = 3'b010;
      expect_req(1'b0, 2'd1, 32'h77);
      e0 = err_seen;
      serve_read(1, 0, 0, 101);
      repeat (15) tick();
      check("to_no_early_err", 32'(err_seen - e0), 32'd0);
      tick();
      check("to_err_once", 32'(err_seen - e0), 32'd1);
      check("to_idle", 32'(busy), 32'd0);
      check("to_ack_drop", 32'(sd_ack), 32'd0);
      check("to_addr_clear", 32'(sd_buff_addr), 32'd0);
      repeat (5) tick();
      check("to_err_single", 32'(err_seen - e0), 32'd1);
      sd_lba2 = 32'h55;
      sd_rd   = 3'b100;
      expect_req(1'b0, 2'd2, 32'h55);
      s0 = strobe_cnt;
      serve_read(0, 1, 5, 512);
      check("to_next_strobes", 32'(strobe_cnt - s0), 32'd512);
      tick();

      // Asynchronous reset in the middle of byte 200.
      sd_lba0 = 32'h300;
      sd_rd   = 3'b001;
      expect_req(1'b0, 2'd0, 32'h300);
      serve_read(0, 2, 0, 200);
      check("rst_mid_addr", 32'(sd_buff_addr), 32'd200);
      host_rd_valid = 1'b1;
      host_rd_data  = pat(2, 200);
      #2;
      reset = 1'b1;
      #1;
      check_idle_outputs("rst_async");
      tick();
      tick();
      host_rd_valid = 1'b0;
      reset = 1'b0;
      tick();
      check_idle_outputs("rst_after");

`ifdef SD_BRIDGE_WRITE_EN
      // Write from slot 2, din2 = addr^0x5A one cycle after the address, host ready every other cycle.
      begin
         bit ok;
         sd_lba2 = 32'h9999;
         sd_wr   = 3'b100;
         expect_req(1'b1, 2'd2, 32'h9999);
         wait_req(ok);
         if (ok) begin
            grant(2);
            for (int i = 0; i < 512; i++) exp_host_q.push_back(8'(i) ^ 8'h5A);
            wr_acc = 0;
            for (int k = 0; k < 4000 && wr_acc < 512; k++) begin
               host_wr_ready = k[0];
               tick();
            end
            host_wr_ready = 1'b0;
            check("wr_count", 32'(wr_acc), 32'd512);
            check("wr_queue_empty", 32'(exp_host_q.size()), 32'd0);
            check("wr_done_busy", 32'(busy), 32'd1);
            check("wr_done_valid", 32'(host_wr_valid), 32'd0);
            tick();
            check("wr_idle", 32'(busy), 32'd0);
         end
      end
`else
      // Without the write path, sd_wr alone must never start a transfer.
      sd_wr = 3'b001;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("nowr_host_req", 32'(host_req), 32'd0);
         check("nowr_busy", 32'(busy), 32'd0);
      end
      sd_wr = 3'b000;
`endif

      tick();
      check("final_strobe_queue", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
